// File: rtl/iwdg_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : iwdg_rst_ctrl
// Brief   : Stretches watchdog/software reset events into a glitch-free
//           system reset; keeps sticky cause flags on a Wishbone slave port.
// Revision: 1.0
// ============================================================================
module iwdg_rst_ctrl #(
    parameter logic [31:0] BASE_ADR       = 32'h0100_0100,
    parameter int          STRETCH_CYCLES = 64,
    parameter int          HOLDOFF_CYCLES = 16,
    parameter logic [15:0] SWRST_KEY      = 16'h5FA0
) (
    input  logic        clk_m2s,
    input  logic        rst_m2s_n,
    input  logic        rst_iwdg,
    input  logic [31:0] dat_m2s,
    input  logic [31:0] adr_m2s,
    input  logic [3:0]  sel_m2s,
    input  logic        cyc_m2s,
    input  logic        stb_m2s,
    input  logic        we_m2s,
    output logic [31:0] dat_s2m,
    output logic        ack_s2m,
    output logic        err_s2m,
    output logic        rty_s2m,
    output logic        sys_rst
);

    localparam int                  c_MAX_CYC    = (STRETCH_CYCLES > HOLDOFF_CYCLES) ?
                                                   STRETCH_CYCLES : HOLDOFF_CYCLES;
    localparam int                  c_CNT_W      = $clog2(c_MAX_CYC);
    localparam logic [c_CNT_W-1:0]  c_STRETCH_LD = c_CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_HOLDOFF_LD = c_CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [31:0]         c_SWRST_ADR  = BASE_ADR + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic               r_iwdg_s1, r_iwdg_s2, r_iwdg_s3, r_iwdg_evt;
    logic               r_ack, r_err, r_sw_evt;
    logic [31:0]        r_dat;
    logic               r_iwdgrstf, r_sftrstf, r_sys_rst;
    logic [7:0]         r_iwdg_cnt;
    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_pend, w_pend_nxt;

    logic        w_req, w_hit_csr, w_hit_swrst, w_wr, w_sw_match, w_rmvf, w_evt;
    logic [31:0] w_csr_rd;
    logic        w_unused;

    // Two-flop synchronizer into clk_m2s, then a registered rising-edge detect
    always_ff @(posedge clk_m2s or negedge rst_m2s_n) begin
        if (!rst_m2s_n) begin
            r_iwdg_s1  <= 1'b0;
            r_iwdg_s2  <= 1'b0;
            r_iwdg_s3  <= 1'b0;
            r_iwdg_evt <= 1'b0;
        end else begin
            r_iwdg_s1  <= rst_iwdg;
            r_iwdg_s2  <= r_iwdg_s1;
            r_iwdg_s3  <= r_iwdg_s2;
            r_iwdg_evt <= r_iwdg_s2 & ~r_iwdg_s3;
        end
    end

    assign w_req       = cyc_m2s & stb_m2s & ~r_ack & ~r_err;
    assign w_hit_csr   = (adr_m2s == BASE_ADR);
    assign w_hit_swrst = (adr_m2s == c_SWRST_ADR);
    assign w_wr        = w_req & we_m2s;
    assign w_sw_match  = w_wr & w_hit_swrst & (sel_m2s[1:0] == 2'b11) &
                         (dat_m2s[15:0] == SWRST_KEY);
    assign w_rmvf      = w_wr & w_hit_csr & sel_m2s[3] & dat_m2s[24];
    assign w_csr_rd    = {16'h0000, r_iwdg_cnt, 5'b00000, r_sys_rst, r_sftrstf, r_iwdgrstf};
    assign w_unused    = ^{dat_m2s[31:25], dat_m2s[23:16], sel_m2s[2]};

    always_ff @(posedge clk_m2s or negedge rst_m2s_n) begin
        if (!rst_m2s_n) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= 32'h0;
            r_sw_evt <= 1'b0;
        end else begin
            r_ack    <= w_req & (w_hit_csr | w_hit_swrst);
            r_err    <= w_req & ~(w_hit_csr | w_hit_swrst);
            r_dat    <= (w_req & ~we_m2s & w_hit_csr) ? w_csr_rd : 32'h0;
            r_sw_evt <= w_sw_match;
        end
    end

    // Later assignments win, so a set in the same cycle as RMVF survives
    always_ff @(posedge clk_m2s or negedge rst_m2s_n) begin
        if (!rst_m2s_n) begin
            r_iwdgrstf <= 1'b0;
            r_sftrstf  <= 1'b0;
            r_iwdg_cnt <= 8'h00;
        end else begin
            if (w_rmvf) begin
                r_iwdgrstf <= 1'b0;
                r_sftrstf  <= 1'b0;
                r_iwdg_cnt <= 8'h00;
            end
            if (r_iwdg_evt) begin
                r_iwdgrstf <= 1'b1;
                if (w_rmvf)
                    r_iwdg_cnt <= 8'h01;
                else if (r_iwdg_cnt != 8'hFF)
                    r_iwdg_cnt <= r_iwdg_cnt + 8'h01;
            end
            if (r_sw_evt)
                r_sftrstf <= 1'b1;
        end
    end

    assign w_evt = r_iwdg_evt | r_sw_evt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        case (r_state)
            ST_IDLE: begin
                if (w_evt) begin
                    w_cnt_nxt   = c_STRETCH_LD;
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (w_evt) begin
                    w_cnt_nxt = c_STRETCH_LD;
                end else if (r_cnt == '0) begin
                    w_cnt_nxt   = c_HOLDOFF_LD;
                    w_state_nxt = ST_HOLDOFF;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt == '0) begin
                    if (r_pend | w_evt) begin
                        w_pend_nxt  = 1'b0;
                        w_cnt_nxt   = c_STRETCH_LD;
                        w_state_nxt = ST_ASSERT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt - c_CNT_W'(1);
                    w_pend_nxt = r_pend | w_evt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    // sys_rst comes straight from a flop so it cannot glitch on state decode
    always_ff @(posedge clk_m2s or negedge rst_m2s_n) begin
        if (!rst_m2s_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_sys_rst <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend    <= w_pend_nxt;
            r_sys_rst <= (w_state_nxt == ST_ASSERT);
        end
    end

    assign dat_s2m = r_dat;
    assign ack_s2m = r_ack;
    assign err_s2m = r_err;
    assign rty_s2m = 1'b0;
    assign sys_rst = r_sys_rst;

endmodule
`default_nettype wire

// File: tb/tb_iwdg_rst_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_iwdg_rst_ctrl
// Brief   : Randomized scoreboard bench for iwdg_rst_ctrl with an
//           interval-based reference model of the reset stretcher.
// Revision: 1.0
// ============================================================================
module tb_iwdg_rst_ctrl;

    localparam logic [31:0] c_BASE = 32'h0100_0100;
    localparam logic [31:0] c_SWA  = 32'h0100_0104;
    localparam logic [15:0] c_KEY  = 16'h5FA0;
    localparam int          c_STR  = 64;
    localparam int          c_HOLD = 16;

    logic        clk_m2s, rst_m2s_n, rst_iwdg;
    logic [31:0] dat_m2s, adr_m2s, dat_s2m;
    logic [3:0]  sel_m2s;
    logic        cyc_m2s, stb_m2s, we_m2s, ack_s2m, err_s2m, rty_s2m, sys_rst;

    iwdg_rst_ctrl dut (
        .clk_m2s  (clk_m2s),
        .rst_m2s_n(rst_m2s_n),
        .rst_iwdg (rst_iwdg),
        .dat_m2s  (dat_m2s),
        .adr_m2s  (adr_m2s),
        .sel_m2s  (sel_m2s),
        .cyc_m2s  (cyc_m2s),
        .stb_m2s  (stb_m2s),
        .we_m2s   (we_m2s),
        .dat_s2m  (dat_s2m),
        .ack_s2m  (ack_s2m),
        .err_s2m  (err_s2m),
        .rty_s2m  (rty_s2m),
        .sys_rst  (sys_rst)
    );

    initial clk_m2s = 1'b0;
    always #5 clk_m2s = ~clk_m2s;

    typedef struct {
        int          edge_n;
        bit          is_err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;
    bit   iw_at[int];
    bit   sw_at[int];
    bit   clr_at[int];

    // Reference model: sys_rst is high over the edge interval [m_hs, m_he)
    int   m_hs = -1000, m_he = -1000, m_cnt = 0;
    bit   m_pend = 0, m_rst = 0, m_fi = 0, m_fs = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc_n);
        end
    endfunction

    function automatic logic [31:0] model_csr();
        logic [7:0] c;
        c = 8'(m_cnt);
        return {16'h0000, c, 5'b00000, m_rst, m_fs, m_fi};
    endfunction

    always @(posedge clk_m2s) begin
        int  x;
        bit  ev;
        cyc_n++;
        x = cyc_n;
        if (!rst_m2s_n) begin
            m_hs = -1000; m_he = -1000; m_pend = 0; m_rst = 0;
            m_fi = 0; m_fs = 0; m_cnt = 0;
        end else begin
            ev = iw_at.exists(x) || sw_at.exists(x);
            if (ev) begin
                if (x - 1 >= m_hs && x - 1 < m_he)
                    m_he = x + c_STR;
                else if (x - 1 >= m_he && x - 1 < m_he + c_HOLD)
                    m_pend = 1;
                else begin
                    m_hs = x; m_he = x + c_STR;
                end
            end
            if (m_pend && x == m_he + c_HOLD) begin
                m_hs = x; m_he = x + c_STR; m_pend = 0;
            end
            m_rst = (x >= m_hs && x < m_he);
            if (clr_at.exists(x)) begin
                m_fi = 0; m_fs = 0; m_cnt = 0;
            end
            if (iw_at.exists(x)) begin
                m_fi = 1;
                if (m_cnt < 255) m_cnt++;
            end
            if (sw_at.exists(x)) m_fs = 1;
        end
    end

    // Monitor: checks sys_rst each cycle and pops the scoreboard on responses
    always @(negedge clk_m2s) begin
        rsp_t r;
        if (rst_m2s_n) begin
            chk("sys_rst", {31'b0, sys_rst}, {31'b0, m_rst});
            chk("rty", {31'b0, rty_s2m}, 32'h0);
            if (ack_s2m || err_s2m) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_rsp: got ack=%b err=%b expected none", ack_s2m, err_s2m);
                end else begin
                    r = sb_q.pop_front();
                    chk("rsp_edge", cyc_n, r.edge_n);
                    chk("rsp_kind", {30'b0, ack_s2m, err_s2m}, {30'b0, !r.is_err, r.is_err});
                    chk("rsp_dat", dat_s2m, r.dat);
                end
            end else begin
                chk("dat_idle", dat_s2m, 32'h0);
            end
            while (sb_q.size() > 0 && sb_q[0].edge_n < cyc_n) begin
                r = sb_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missing_rsp: got nothing expected response at edge %0d", r.edge_n);
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk_m2s);
        #1;
    endtask

    task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        rsp_t r;
        int   n;
        bit   hc, hs;
        n  = cyc_n;
        hc = (adr == c_BASE);
        hs = (adr == c_SWA);
        r.edge_n = n + 1;
        r.is_err = !(hc || hs);
        r.dat    = (!we && hc) ? model_csr() : 32'h0;
        if (we && hc && sel[3] && dat[24]) clr_at[n + 1] = 1;
        if (we && hs && sel[1:0] == 2'b11 && dat[15:0] == c_KEY) sw_at[n + 2] = 1;
        sb_q.push_back(r);
        cyc_m2s = 1; stb_m2s = 1; we_m2s = we; adr_m2s = adr; dat_m2s = dat; sel_m2s = sel;
        idle(1);
        cyc_m2s = 0; stb_m2s = 0; we_m2s = 0;
        idle(1);
    endtask

    task automatic pulse();
        iw_at[cyc_n + 4] = 1;
        rst_iwdg = 1;
        idle(3);
        rst_iwdg = 0;
        idle(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_m2s_n = 0; rst_iwdg = 0; dat_m2s = 0; adr_m2s = 0; sel_m2s = 0;
        cyc_m2s = 0; stb_m2s = 0; we_m2s = 0;
        idle(3);
        rst_m2s_n = 1;
        idle(2);
        chk("reset_sys_rst", {31'b0, sys_rst}, 32'h0);
        chk("reset_ack", {31'b0, ack_s2m}, 32'h0);
        bus(0, c_BASE, 0, 4'hF);

        pulse();
        idle(90);
        bus(0, c_BASE, 0, 4'hF);

        bus(1, c_SWA, 32'h0000_5FA0, 4'hF);
        idle(90);
        bus(0, c_BASE, 0, 4'hF);
        bus(1, c_SWA, 32'h0000_1234, 4'hF);
        idle(5);

        pulse();
        idle(30);
        pulse();
        idle(100);
        pulse();
        idle(70);
        pulse();
        idle(120);

        for (int i = 0; i < 300; i++) pulse();
        idle(100);
        bus(0, c_BASE, 0, 4'hF);
        bus(1, c_BASE, 32'h0100_0000, 4'hF);
        bus(0, c_BASE, 0, 4'hF);

        pulse();
        idle(90);
        iw_at[cyc_n + 4] = 1;
        rst_iwdg = 1;
        idle(3);
        bus(1, c_BASE, 32'h0100_0000, 4'hF);
        rst_iwdg = 0;
        idle(100);
        bus(0, c_BASE, 0, 4'hF);

        bus(0, c_BASE + 32'd8, 0, 4'hF);
        bus(1, c_BASE + 32'd8, 32'h0100_0000, 4'hF);
        bus(0, c_BASE, 0, 4'hF);

        for (int i = 0; i < 150; i++) begin
            int          op;
            logic [31:0] d;
            logic [3:0]  s;
            op = $urandom_range(0, 5);
            d  = $urandom;
            s  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            idle($urandom_range(0, 40));
            case (op)
                0: pulse();
                1: bus(1, c_SWA, {d[31:16], c_KEY}, s);
                2: bus(1, c_SWA, d, s);
                3: bus(0, c_BASE, d, s);
                4: bus(1, c_BASE, d, s);
                default: bus($urandom_range(0, 1) == 1, c_BASE + 32'd8 + {d[5:0], 2'b00}, d, s);
            endcase
        end
        idle(200);

        pulse();
        idle(20);
        rst_m2s_n = 0;
        #1;
        chk("async_rst_drop", {31'b0, sys_rst}, 32'h0);
        idle(2);
        rst_m2s_n = 1;
        idle(2);
        bus(0, c_BASE, 0, 4'hF);
        idle(5);

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL outstanding_rsp: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
